// File: rtl/fetch_unit.sv
// Fetch stage: holds PC/IR, computes next PC, and runs a req/ack fetch with instruction memory.
// imem_req rises the cycle after IRWre and holds until the ack edge; the next IR loads at least two edges after IRWre.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCWE,
   input  logic        IRWre,
   input  logic [1:0]  npc_sel,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] ir,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm16,
   output logic        ir_valid,
   output logic        fetch_busy
);

   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_ir, w_ir_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic        r_req, w_req_nxt;
   logic        r_irv, w_irv_nxt;
   logic        r_first, w_first_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_br_off;
   logic [31:0] w_npc;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_off   = {{14{r_ir[15]}}, r_ir[15:0], 2'b00};

   always_comb begin
      w_npc = w_pc_plus4;
      case (npc_sel)
         2'b01:   w_npc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
         2'b11:   w_npc = w_pc_plus4 + w_br_off;
         default: w_npc = w_pc_plus4;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_addr_nxt  = r_addr;
      w_req_nxt   = r_req;
      w_irv_nxt   = 1'b0;
      w_first_nxt = r_first;
      case (r_state)
         S_IDLE: begin
            if (IRWre) begin
               // The very first fetch after reset uses RESET_PC itself, not its successor.
               if (r_first) begin
                  w_addr_nxt  = r_pc;
                  w_first_nxt = 1'b0;
               end else if (PCWE) begin
                  w_pc_nxt   = w_npc;
                  w_addr_nxt = w_npc;
               end else begin
                  w_addr_nxt = r_pc;
               end
               w_req_nxt   = 1'b1;
               w_state_nxt = S_WAIT;
            end else if (PCWE) begin
               w_pc_nxt    = w_npc;
               w_first_nxt = 1'b0;
            end
         end
         S_WAIT: begin
            if (imem_ack) begin
               w_ir_nxt    = imem_rdata;
               w_req_nxt   = 1'b0;
               w_irv_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= PC_INIT;
         r_ir    <= 32'h0;
         r_addr  <= PC_INIT;
         r_req   <= 1'b0;
         r_irv   <= 1'b0;
         r_first <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_addr  <= w_addr_nxt;
         r_req   <= w_req_nxt;
         r_irv   <= w_irv_nxt;
         r_first <= w_first_nxt;
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_addr;
   assign pc         = r_pc;
   assign pc_plus4   = w_pc_plus4;
   assign ir         = r_ir;
   assign op         = r_ir[31:26];
   assign funct      = r_ir[5:0];
   assign rs         = r_ir[25:21];
   assign rt         = r_ir[20:16];
   assign rd         = r_ir[15:11];
   assign imm16      = r_ir[15:0];
   assign ir_valid   = r_irv;
   assign fetch_busy = (r_state == S_WAIT);

endmodule
